// File: rtl/imem_loader_if.sv
// Fetch and program-load bundle for imem_loader.
// master: core/host side; slave: the loader.
interface imem_loader_if #(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 14
);
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] instruction;
  logic               ld_start;
  logic               ld_valid;
  logic [7:0]         ld_data;
  logic               ld_last;
  logic               ld_ready;
  logic               core_hold;
  logic               ld_done;
  logic               ld_err;
  logic [ADDR_W:0]    ld_count;

  modport master (
    output pc, ld_start, ld_valid,
    output ld_data, ld_last,
    input  instruction, ld_ready,
    input  core_hold, ld_done,
    input  ld_err, ld_count
  );

  modport slave (
    input  pc, ld_start, ld_valid,
    input  ld_data, ld_last,
    output instruction, ld_ready,
    output core_hold, ld_done,
    output ld_err, ld_count
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction store with run-time byte-stream reload.
// Ports: clk, rst (sync, active-high), bus (imem_loader_if.slave).
// Option: IMEM_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader #(
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 14
) (
  input logic          clk,
  input logic          rst,
  imem_loader_if.slave bus
);

`ifdef IMEM_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE, LOAD_LO, LOAD_HI, CHK
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, LOAD_LO, LOAD_HI
  } state_t;
`endif

  logic [INSTR_W-1:0] mem [DEPTH];

  state_t            state;
  state_t            nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   count;
  logic [7:0]        lo;
  logic              done;
  logic              ready;
  logic              wr;
  logic              fin;
  logic              clr;
  logic              last_word;

  assign last_word = bus.ld_last
    | (addr == ADDR_W'(DEPTH - 1));

`ifdef IMEM_CHECKSUM_EN
  logic [7:0] csum;
  logic       err;
  logic       set_err;
`endif

  always_comb begin
    nxt   = state;
    ready = 1'b0;
    wr    = 1'b0;
    fin   = 1'b0;
    clr   = 1'b0;
`ifdef IMEM_CHECKSUM_EN
    set_err = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (bus.ld_start) begin
          nxt = LOAD_LO;
          clr = 1'b1;
        end
      end
      LOAD_LO: begin
        ready = 1'b1;
        if (bus.ld_valid) nxt = LOAD_HI;
      end
      LOAD_HI: begin
        ready = 1'b1;
        if (bus.ld_valid) begin
          wr = 1'b1;
          if (last_word) begin
`ifdef IMEM_CHECKSUM_EN
            nxt = CHK;
`else
            nxt = IDLE;
            fin = 1'b1;
`endif
          end else begin
            nxt = LOAD_LO;
          end
        end
      end
`ifdef IMEM_CHECKSUM_EN
      // A failed check parks here until a
      // restart; no further bytes are taken.
      CHK: begin
        ready = !err;
        if (bus.ld_start) begin
          nxt = LOAD_LO;
          clr = 1'b1;
        end else if (bus.ld_valid && !err) begin
          if (bus.ld_data == csum) begin
            nxt = IDLE;
            fin = 1'b1;
          end else begin
            set_err = 1'b1;
          end
        end
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr  <= '0;
      count <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= fin;
      if (clr) begin
        addr  <= '0;
        count <= '0;
      end
      if (state == LOAD_LO && bus.ld_valid)
        lo <= bus.ld_data;
      if (wr) begin
        addr  <= addr + ADDR_W'(1);
        count <= count + (ADDR_W+1)'(1);
      end
    end
  end

`ifdef IMEM_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= '0;
      err  <= 1'b0;
    end else if (clr) begin
      csum <= '0;
      err  <= 1'b0;
    end else begin
      if (ready && bus.ld_valid
          && state != CHK)
        csum <= csum ^ bus.ld_data;
      if (set_err) err <= 1'b1;
    end
  end
  assign bus.ld_err = err;
`else
  assign bus.ld_err = 1'b0;
`endif

  // Store has no reset so a reset mid-load
  // keeps the words already written.
  always_ff @(posedge clk) begin
    if (wr && !rst)
      mem[addr] <= {bus.ld_data[INSTR_W-9:0], lo};
  end

  assign bus.ld_ready    = ready;
  assign bus.core_hold   = (state != IDLE);
  assign bus.ld_done     = done;
  assign bus.ld_count    = count;
  assign bus.instruction = (state != IDLE)
    ? '0 : mem[bus.pc];

endmodule
